// File: rtl/fp_arb_pkg.sv
// Shared helpers for the FP round-robin arbiter: one-hot to index
// conversion and the mod-N pointer increment, sized for the largest N.
package fp_arb_pkg;

   localparam int MAX_N   = 32;
   localparam int MAX_IDW = $clog2(MAX_N);

   // Binary index of the set bit of a one-hot vector (0 for all zeros).
   function automatic logic [MAX_IDW-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
      logic [MAX_IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++)
         if (oh[i]) idx = idx | MAX_IDW'(i);
      return idx;
   endfunction

   // (idx + 1) mod n, with the wrap explicit so non-power-of-two n works.
   function automatic logic [MAX_IDW-1:0] rr_next_ptr(input logic [MAX_IDW-1:0] idx,
                                                     input logic [MAX_IDW:0]   n);
      if ({1'b0, idx} == n - (MAX_IDW+1)'(1))
         return '0;
      else
         return idx + MAX_IDW'(1);
   endfunction

endpackage

// File: rtl/fp_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above ptr,
// falling back to the lowest set request overall. Output is one-hot or zero.
module fp_rr_pick #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   pick
);

   logic [N-1:0] masked;
   logic [N-1:0] pick_m;
   logic [N-1:0] pick_u;

   // Requests at or above the pointer form the first-choice set.
   always_comb begin
      masked = '0;
      for (int i = 0; i < N; i++)
         masked[i] = req[i] && (i >= int'(ptr));
   end

   // Lowest set bit of each set; scanning downward leaves the lowest winner.
   always_comb begin
      pick_m = '0;
      pick_u = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (masked[i]) begin
            pick_m    = '0;
            pick_m[i] = 1'b1;
         end
         if (req[i]) begin
            pick_u    = '0;
            pick_u[i] = 1'b1;
         end
      end
   end

   assign pick = (|masked) ? pick_m : pick_u;

endmodule

// File: rtl/fp_rr_arb.sv
// Round-robin arbiter for the shared FP execution unit.
// Registered one-hot grant plus index; busy freezes grant and pointer.
// Optional macro FP_ARB_PRIO_EN adds req_hi: round-robin runs over
// req & req_hi when that set is non-empty, sharing the same pointer.
module fp_rr_arb
   import fp_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
`ifdef FP_ARB_PRIO_EN
   input  logic [N-1:0]   req_hi,
`endif
   input  logic           busy,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_vld
);

   logic [N-1:0]     gnt_q;
   logic [IDW-1:0]   id_q;
   logic [IDW-1:0]   ptr_q;
   logic [N-1:0]     pick_all;
   logic [N-1:0]     win;
   logic [MAX_N-1:0] win_ext;
   logic [IDW-1:0]   id_d;
   logic [IDW-1:0]   ptr_d;

   fp_rr_pick #(.N(N), .IDW(IDW)) u_pick_all (
      .req  (req),
      .ptr  (ptr_q),
      .pick (pick_all)
   );

`ifdef FP_ARB_PRIO_EN
   logic [N-1:0] hi_set;
   logic [N-1:0] pick_hi;

   // req_hi without a matching req is meaningless, so it is masked off.
   assign hi_set = req & req_hi;

   fp_rr_pick #(.N(N), .IDW(IDW)) u_pick_hi (
      .req  (hi_set),
      .ptr  (ptr_q),
      .pick (pick_hi)
   );

   assign win = (|hi_set) ? pick_hi : pick_all;
`else
   assign win = pick_all;
`endif

   // Winner index and the pointer that gives the winner lowest priority next.
   always_comb begin
      win_ext         = '0;
      win_ext[N-1:0]  = win;
      id_d            = IDW'(onehot2idx(win_ext));
      ptr_d           = IDW'(rr_next_ptr(MAX_IDW'(id_d), (MAX_IDW+1)'(N)));
   end

   // Grant/pointer registers; busy holds everything, no request clears grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q <= '0;
         id_q  <= '0;
         ptr_q <= '0;
      end else if (!busy) begin
         gnt_q <= win;
         id_q  <= id_d;
         if (|win) ptr_q <= ptr_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = id_q;
   assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_fp_rr_arb.sv
// Randomized + directed bench for fp_rr_arb, instances with N=4 and N=3,
// checked against a scan-based reference model of the arbitration rules.
module tb_fp_rr_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] req_hi;
   logic       busy;

   logic [3:0] g4;
   logic [1:0] id4;
   logic       v4;
   logic [2:0] g3;
   logic [1:0] id3;
   logic       v3;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state per instance: 0 -> N=4, 1 -> N=3
   int m_n   [2] = '{4, 3};
   int m_ptr [2];
   int m_win [2];   // -1 = no grant

   always #5 clk = ~clk;

   fp_rr_arb #(.N(4)) u_dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
`ifdef FP_ARB_PRIO_EN
      .req_hi  (req_hi),
`endif
      .busy    (busy),
      .gnt     (g4),
      .gnt_id  (id4),
      .gnt_vld (v4)
   );

   fp_rr_arb #(.N(3)) u_dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[2:0]),
`ifdef FP_ARB_PRIO_EN
      .req_hi  (req_hi[2:0]),
`endif
      .busy    (busy),
      .gnt     (g3),
      .gnt_id  (id3),
      .gnt_vld (v3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ptr[d] = 0;
         m_win[d] = -1;
      end
   endtask

   // One arbitration as the rules describe it: scan from the pointer upward with wrap.
   task automatic model_edge();
      int n, w, idx;
      logic [3:0] src, hs;
      if (busy) return;
      for (int d = 0; d < 2; d++) begin
         n  = m_n[d];
         hs = 4'b0;
`ifdef FP_ARB_PRIO_EN
         hs = req & req_hi;
`endif
         src = (hs != 4'b0) ? hs : req;
         w = -1;
         for (int k = 0; k < n; k++) begin
            idx = (m_ptr[d] + k) % n;
            if (w < 0 && src[idx]) w = idx;
         end
         m_win[d] = w;
         if (w >= 0) m_ptr[d] = (w + 1) % n;
      end
   endtask

   function automatic logic [31:0] exp_gnt(input int d);
      return (m_win[d] < 0) ? 32'd0 : (32'd1 << m_win[d]);
   endfunction

   function automatic logic [31:0] exp_id(input int d);
      return (m_win[d] < 0) ? 32'd0 : 32'(m_win[d]);
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".gnt4"},  32'(g4),  exp_gnt(0));
      chk({tag, ".id4"},   32'(id4), exp_id(0));
      chk({tag, ".vld4"},  32'(v4),  32'(m_win[0] >= 0));
      chk({tag, ".gnt3"},  32'(g3),  exp_gnt(1));
      chk({tag, ".id3"},   32'(id3), exp_id(1));
      chk({tag, ".vld3"},  32'(v3),  32'(m_win[1] >= 0));
   endtask

   // Advance one clock, update the model with the inputs sampled at that edge, compare.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [3:0] rot4 [5];
      logic [2:0] rot3 [4];
      rot4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rot3 = '{3'b001, 3'b010, 3'b100, 3'b001};

      rst_n  = 1'b0;
      req    = '0;
      req_hi = '0;
      busy   = 1'b0;
      model_reset();
      #3;
      check_outputs("in_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 10; i++) step("idle");

      // rotation, all requesting
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step("rot");
         chk("rot4.const", 32'(g4), 32'(rot4[i]));
         if (i < 4) chk("rot3.const", 32'(g3), 32'(rot3[i]));
      end
      step("rot");
      chk("pre_busy.const", 32'(g4), 32'h2);

      // busy hold while req changes
      busy = 1'b1;
      req  = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         step("busy");
         chk("busy_hold.const", 32'(g4), 32'h2);
      end
      busy = 1'b0;
      step("unbusy");
      chk("after_busy.const", 32'(g4), 32'h8);

      // sole requester at the top index, then wrap to 0
      req = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         step("sole");
         chk("sole.const", 32'(g4), 32'h8);
      end
      req = 4'b1001;
      step("wrap");
      chk("wrap.const", 32'(g4), 32'h1);

      // busy while idle keeps zero, then service at first edge after busy falls
      req = 4'b0000;
      step("idle2");
      busy = 1'b1;
      req  = 4'b0110;
      for (int i = 0; i < 3; i++) step("busy_idle");
      chk("busy_idle.const", 32'(v4), 32'h0);
      busy = 1'b0;
      step("busy_idle_rel");
      chk("busy_idle_rel.const", 32'(g4), 32'h2);

`ifdef FP_ARB_PRIO_EN
      req    = 4'b1111;
      req_hi = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         step("prio");
         chk("prio.const", 32'(g4), 32'h4);
      end
      req_hi = 4'b0000;
      step("prio_off");
      chk("prio_off.const", 32'(g4), 32'h8);
`endif

      // randomized traffic with occasional asynchronous reset mid-cycle
      for (int i = 0; i < 600; i++) begin
         busy   = ($urandom_range(0, 3) == 0);
         req    = 4'($urandom);
         req_hi = 4'($urandom & $urandom);
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs("async_rst");
            #1;
            rst_n = 1'b1;
         end
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
